// File: rtl/ps2_key_emulator_pkg.sv
// Shared constants, state types and scan-code sequencing helpers for the
// PS/2 keyboard emulator.
package ps2_pkg;

  localparam logic [7:0]  PS2_EXT_PREFIX   = 8'hE0;
  localparam logic [7:0]  PS2_BREAK_PREFIX = 8'hF0;
  localparam int unsigned PS2_FRAME_BITS   = 11;

  // Event-level sequencer states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FRAME,
    ST_GAP,
    ST_DONE
  } key_state_t;

  // Single-frame serialiser states
  typedef enum logic [1:0] {
    TX_IDLE,
    TX_BIT_HI,
    TX_BIT_LO
  } tx_state_t;

  // Index of the final byte of a sequence: one extra byte per prefix.
  function automatic logic [1:0] seq_last(input logic ext, input logic brk);
    return {1'b0, ext} + {1'b0, brk};
  endfunction

  // Byte at position idx of the sequence [E0] [F0] code.
  function automatic logic [7:0] seq_byte(input logic [1:0] idx,
                                          input logic       ext,
                                          input logic       brk,
                                          input logic [7:0] code);
    logic [7:0] b;
    b = code;
    case (idx)
      2'd0: begin
        if (ext)      b = PS2_EXT_PREFIX;
        else if (brk) b = PS2_BREAK_PREFIX;
      end
      2'd1: begin
        if (ext && brk) b = PS2_BREAK_PREFIX;
      end
      default: b = code;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ps2_key_emulator_frame_tx.sv
// Serialises one byte as an 11-bit device-to-host PS/2 frame:
// start(0), d0..d7, odd parity, stop(1). Data changes at the start of each
// clock-high half so it is stable across every falling edge.
module ps2_frame_tx
  import ps2_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 2000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       start,
  input  logic [7:0] data_byte,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       frame_done
);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_PERIOD - 1);
  localparam logic [3:0]       LAST_BIT  = 4'(PS2_FRAME_BITS - 1);

  tx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       bit_idx;
  logic [9:0]       shreg;

  // Frame FSM with registered line outputs
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= TX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      ps2_clk    <= 1'b1;
      ps2_data   <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        TX_IDLE: begin
          ps2_clk  <= 1'b1;
          ps2_data <= 1'b1;
          cnt      <= '0;
          if (start) begin
            // remaining bits after the start bit: d0..d7, parity, stop
            shreg    <= {1'b1, ~^data_byte, data_byte};
            ps2_data <= 1'b0;
            bit_idx  <= '0;
            state    <= TX_BIT_HI;
          end
        end
        TX_BIT_HI: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            ps2_clk <= 1'b0;
            state   <= TX_BIT_LO;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TX_BIT_LO: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            ps2_clk <= 1'b1;
            if (bit_idx == LAST_BIT) begin
              ps2_data   <= 1'b1;
              frame_done <= 1'b1;
              state      <= TX_IDLE;
            end else begin
              bit_idx  <= bit_idx + 1'b1;
              ps2_data <= shreg[0];
              shreg    <= {1'b1, shreg[9:1]};
              state    <= TX_BIT_HI;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_emulator.sv
// Device-side PS/2 keyboard emulator: turns a make/break request for a
// 9-bit key code into its scan-code byte sequence and sends each byte as a
// PS/2 frame, with idle gaps between frames of one event.
module ps2_key_emulator
  import ps2_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 2000,
  parameter int unsigned BYTE_GAP    = 4000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [8:0] keyCode,
  input  logic       make,
  input  logic       brakee,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic       done
);

  // The frame_done register and the LOAD state each add one idle-high cycle,
  // so the GAP state itself runs BYTE_GAP-2 cycles (BYTE_GAP must be >= 3)
  // to keep the line-idle time between frames at exactly BYTE_GAP.
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(BYTE_GAP - 3);

  key_state_t       state;
  logic [7:0]       code_q;
  logic             ext_q;
  logic             brk_q;
  logic [1:0]       byte_idx;
  logic [CNT_W-1:0] gap_cnt;

  logic             frame_start;
  logic [7:0]       frame_byte;
  logic             frame_done;

  // Start strobe and byte selection are decoded from registered state only
  always_comb begin
    frame_start = (state == ST_LOAD);
    frame_byte  = seq_byte(byte_idx, ext_q, brk_q, code_q);
  end

  // Request capture, byte sequencing and inter-frame gap timing
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state    <= ST_IDLE;
      code_q   <= '0;
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      byte_idx <= '0;
      gap_cnt  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          gap_cnt <= '0;
          if (make || brakee) begin
            code_q   <= keyCode[7:0];
            ext_q    <= keyCode[8];
            brk_q    <= ~make;
            byte_idx <= '0;
            busy     <= 1'b1;
            state    <= ST_LOAD;
          end
        end
        ST_LOAD: state <= ST_FRAME;
        ST_FRAME: begin
          if (frame_done) begin
            if (byte_idx == seq_last(ext_q, brk_q)) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              gap_cnt <= '0;
              state   <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt  <= '0;
            byte_idx <= byte_idx + 1'b1;
            state    <= ST_LOAD;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  ps2_frame_tx #(
    .HALF_PERIOD(HALF_PERIOD),
    .CNT_W      (CNT_W)
  ) u_frame_tx (
    .clk       (clk),
    .resetN    (resetN),
    .start     (frame_start),
    .data_byte (frame_byte),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .frame_done(frame_done)
  );

endmodule

// File: tb/tb_ps2_key_emulator.sv
// Self-checking bench for ps2_key_emulator: table-driven key events with a
// byte scoreboard fed by a PS/2 line monitor, a loopback key decoder model,
// and hand-written busy-ignore and mid-frame reset sequences.
module tb_ps2_key_emulator;

  localparam int unsigned HALF_PERIOD = 4;
  localparam int unsigned BYTE_GAP    = 8;
  localparam int          FRAME_CYC   = 22 * HALF_PERIOD;

  logic       clk;
  logic       resetN;
  logic [8:0] keyCode;
  logic       make;
  logic       brakee;
  logic       ps2_clk;
  logic       ps2_data;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];

  // line monitor / loopback receiver state
  int          nbits = 0;
  logic [10:0] fr;
  logic [10:0] last_frame;
  int          hi_run = 0;
  bit          gap_armed = 0;
  logic        prev_clk = 1'b1;
  logic        prev_data = 1'b1;
  bit          dec_ext = 0;
  bit          dec_brk = 0;
  bit          key_pressed = 0;
  bit          key_toggle = 0;

  typedef struct {
    logic       m;
    logic       b;
    logic [8:0] kc;
    int         nb;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
  } vec_t;

  vec_t vecs[5];

  ps2_key_emulator #(
    .HALF_PERIOD(HALF_PERIOD),
    .BYTE_GAP   (BYTE_GAP),
    .CNT_W      (16)
  ) dut (
    .clk     (clk),
    .resetN  (resetN),
    .keyCode (keyCode),
    .make    (make),
    .brakee  (brakee),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Receiver model: sample data on ps2_clk falling edges, check framing,
  // pop the scoreboard, and run a key decoder for code 9'h01C.
  always @(negedge clk) begin
    logic [7:0] b;
    logic [7:0] e;
    if (!resetN) begin
      nbits       = 0;
      hi_run      = 0;
      gap_armed   = 0;
      dec_ext     = 0;
      dec_brk     = 0;
      key_pressed = 0;
      key_toggle  = 0;
      prev_clk    = 1'b1;
      prev_data   = 1'b1;
    end else begin
      if (ps2_clk && prev_data && !ps2_data && nbits == 0 && gap_armed)
        check("gap_idle_cycles", hi_run, int'(BYTE_GAP));
      if (ps2_clk && ps2_data) hi_run++;
      else hi_run = 0;
      if (prev_clk && !ps2_clk) begin
        fr[nbits] = ps2_data;
        nbits++;
        if (nbits == 11) begin
          nbits      = 0;
          gap_armed  = 1;
          last_frame = fr;
          b          = fr[8:1];
          check("frame_start_bit", int'(fr[0]), 0);
          check("frame_parity", int'(fr[9]), int'(~^b));
          check("frame_stop_bit", int'(fr[10]), 1);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL frame_unexpected actual=%02h required=none", b);
          end else begin
            e = exp_q.pop_front();
            check("frame_byte", int'(b), int'(e));
          end
          if (b == 8'hE0) dec_ext = 1;
          else if (b == 8'hF0) dec_brk = 1;
          else begin
            if ({dec_ext, b} == 9'h01C) begin
              key_pressed = !dec_brk;
              if (!dec_brk) key_toggle = !key_toggle;
            end
            dec_ext = 0;
            dec_brk = 0;
          end
        end
      end
      if (done) gap_armed = 0;
      prev_clk  = ps2_clk;
      prev_data = ps2_data;
    end
  end

  // Drive one request, then time done against the expected latency
  task automatic run_req(input logic m, input logic b, input logic [8:0] kc,
                         input int exp_lat);
    int cyc;
    bit got;
    @(negedge clk);
    check("busy_before_req", int'(busy), 0);
    keyCode = kc;
    make    = m;
    brakee  = b;
    @(posedge clk);
    #1;
    make   = 1'b0;
    brakee = 1'b0;
    check("busy_after_req", int'(busy), 1);
    check("data_high_capture", int'(ps2_data), 1);
    cyc = 0;
    got = 0;
    while (cyc < 2000 && !got) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) check("start_bit_latency", int'(ps2_data), 0);
      if (done) got = 1;
    end
    check("done_seen", int'(got), 1);
    if (got) begin
      check("done_latency", cyc, exp_lat);
      check("busy_at_done", int'(busy), 1);
      @(posedge clk);
      #1;
      check("done_one_cycle", int'(done), 0);
      check("busy_after_done", int'(busy), 0);
    end
    check("scoreboard_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    bad++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int lat;
    int done_cnt;
    int busy_falls;
    int falls;
    bit t0;
    logic pb;
    logic pc;

    vecs[0] = '{m:1'b1, b:1'b0, kc:9'h01C, nb:1, b0:8'h1C, b1:8'h00, b2:8'h00};
    vecs[1] = '{m:1'b0, b:1'b1, kc:9'h175, nb:3, b0:8'hE0, b1:8'hF0, b2:8'h75};
    vecs[2] = '{m:1'b1, b:1'b1, kc:9'h029, nb:1, b0:8'h29, b1:8'h00, b2:8'h00};
    vecs[3] = '{m:1'b1, b:1'b0, kc:9'h174, nb:2, b0:8'hE0, b1:8'h74, b2:8'h00};
    vecs[4] = '{m:1'b0, b:1'b1, kc:9'h05A, nb:2, b0:8'hF0, b1:8'h5A, b2:8'h00};

    resetN  = 1'b0;
    make    = 1'b0;
    brakee  = 1'b0;
    keyCode = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ps2_clk", int'(ps2_clk), 1);
    check("reset_ps2_data", int'(ps2_data), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    @(negedge clk);
    resetN = 1'b1;

    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(vecs[i].b0);
      if (vecs[i].nb > 1) exp_q.push_back(vecs[i].b1);
      if (vecs[i].nb > 2) exp_q.push_back(vecs[i].b2);
      lat = 2 + vecs[i].nb * FRAME_CYC + (vecs[i].nb - 1) * int'(BYTE_GAP);
      run_req(vecs[i].m, vecs[i].b, vecs[i].kc, lat);
      if (i == 0) check("frame_bits_1c", int'(last_frame), 'h438);
    end

    // second make while busy is ignored
    exp_q.push_back(8'h1C);
    @(negedge clk);
    keyCode = 9'h01C;
    make    = 1'b1;
    @(negedge clk);
    make = 1'b0;
    repeat (20) @(negedge clk);
    keyCode = 9'h05A;
    make    = 1'b1;
    @(negedge clk);
    make       = 1'b0;
    done_cnt   = 0;
    busy_falls = 0;
    pb         = busy;
    for (int c = 0; c < 250; c++) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (pb && !busy) busy_falls++;
      pb = busy;
    end
    check("ignore_done_count", done_cnt, 1);
    check("ignore_busy_falls", busy_falls, 1);
    check("ignore_scoreboard", exp_q.size(), 0);
    exp_q.delete();

    // reset in the middle of bit 5
    exp_q.push_back(8'h1C);
    @(negedge clk);
    keyCode = 9'h01C;
    make    = 1'b1;
    @(posedge clk);
    #1;
    make  = 1'b0;
    falls = 0;
    pc    = ps2_clk;
    for (int c = 0; c < 200 && falls < 5; c++) begin
      @(posedge clk);
      #1;
      if (pc && !ps2_clk) falls++;
      pc = ps2_clk;
    end
    check("bit5_reached", falls, 5);
    repeat (HALF_PERIOD + 2) @(posedge clk);
    #3;
    resetN = 1'b0;
    #1;
    check("midreset_ps2_clk", int'(ps2_clk), 1);
    check("midreset_ps2_data", int'(ps2_data), 1);
    check("midreset_busy", int'(busy), 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    resetN = 1'b1;
    exp_q.push_back(8'h1C);
    run_req(1'b1, 1'b0, 9'h01C, 2 + FRAME_CYC);

    // loopback decoder: release then press and release again
    t0 = key_toggle;
    check("loop_pressed_after_make", int'(key_pressed), 1);
    exp_q.push_back(8'hF0);
    exp_q.push_back(8'h1C);
    run_req(1'b0, 1'b1, 9'h01C, 2 + 2 * FRAME_CYC + int'(BYTE_GAP));
    check("loop_released", int'(key_pressed), 0);
    check("loop_toggle_hold", int'(key_toggle), int'(t0));
    exp_q.push_back(8'h1C);
    run_req(1'b1, 1'b0, 9'h01C, 2 + FRAME_CYC);
    check("loop_pressed_again", int'(key_pressed), 1);
    check("loop_toggle_flip", int'(key_toggle), int'(!t0));

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_key_emulator.md
Name: ps2_key_emulator

Overview:
Device-side PS/2 keyboard emulator. It converts a key event (9-bit key code plus make or break request) into the scan-code byte sequence and serialises it onto PS/2 clock and data lines. It is the transmit counterpart of the existing keyboard receive chain (bit receiver → byte decoder → per-key toggle decoders). It drives that chain in loopback for on-board self-test and benches without a physical keyboard.

Parameters:
HALF_PERIOD, 2000, clk cycles per ps2_clk half period (12.5 kHz at 50 MHz); minimum 2
BYTE_GAP, 4000, idle clk cycles (both lines high) between consecutive frames of one event
CNT_W, 16, width of the timing counter; must hold max(HALF_PERIOD, BYTE_GAP)

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
keyCode  in  9  bit8 = extended (E0 prefix), bits7:0 = scan code
make  in  1  one-clock request: send press sequence for keyCode
brakee  in  1  one-clock request: send release sequence for keyCode
ps2_clk  out  1  emulated PS/2 clock, idle high
ps2_data  out  1  emulated PS/2 data, idle high
busy  out  1  high from cycle after accepted request until sequence end
done  out  1  one-clock pulse when last frame's stop bit half-period completes

Behaviour:
- Reset values: ps2_clk=1, ps2_data=1, busy=0, done=0, all counters 0, FSM=IDLE. Reset mid-frame aborts immediately and returns both lines high asynchronously.
- Request capture:
  - In IDLE, make or brakee is sampled on clk; keyCode is latched in the same cycle.
  - make has priority if both are high; brakee is then ignored.
  - Requests while busy=1 are ignored (no queue).
- Byte sequence:
  - make: [E0 if keyCode[8]] code.
  - break: [E0 if keyCode[8]] F0 code.
  - Length is 1 to 3 bytes, tracked by a 2-bit byte index.
- Frame: 11 bits in order start(0), d0..d7 LSB first, odd parity (bit = ~^data), stop(1).
- Per-bit timing:
  - ps2_data changes in the first cycle of the clk-high half.
  - ps2_clk stays high for HALF_PERIOD cycles, then low for HALF_PERIOD cycles.
  - Data is stable across each falling edge.
  - A frame lasts 22*HALF_PERIOD cycles.
- FSM states:
  - IDLE: lines high, busy=0. On accepted request → LOAD.
  - LOAD: select the byte for the current index; load the shift register and bit counter (0..10) → BIT_HI.
  - BIT_HI: drive the current bit with ps2_clk=1; after HALF_PERIOD cycles → BIT_LO.
  - BIT_LO: ps2_clk=0; after HALF_PERIOD cycles, if bit<10 then advance the bit and → BIT_HI. Otherwise, if more bytes remain → GAP; else → DONE.
  - GAP: lines high for BYTE_GAP cycles, then increment the byte index → LOAD.
  - DONE: done=1 for one cycle, busy=0 from the next cycle → IDLE.
- Latency: ps2_data falls (start bit) 2 clk cycles after the request cycle (capture, LOAD). busy rises 1 cycle after the request.
- All outputs are registered; no combinational path from inputs to ps2_clk or ps2_data.
- Counter wrap: the timing counter reloads to 0 on every state change and never free-runs past its terminal count.

Decomposition:
- Shared package ps2_pkg:
  - constants PS2_EXT_PREFIX=8'hE0, PS2_BREAK_PREFIX=8'hF0, PS2_FRAME_BITS=11
  - typedef enum for FSM states
- Sub-module ps2_frame_tx: single-byte serialiser.
  - start/byte in, ps2_clk/ps2_data/frame_done out, HALF_PERIOD parameter.
  - The top level keeps byte sequencing, gap timing and request handling.

Test Plan:
- Use HALF_PERIOD=4, BYTE_GAP=8 throughout.
- make, keyCode=9'h01C → one frame. Bits sampled on ps2_clk falling edges: 0,0,0,1,1,1,0,0,0,0,1 (parity 0). done pulses exactly 88+2 cycles after the request.
- brakee, keyCode=9'h175 → three frames, each separated by 8 idle-high cycles:
  - E0 with parity 0
  - F0 with parity 1
  - 75 with parity 0
- make and brakee in the same cycle, keyCode=9'h029 → single frame 29 only; no F0 frame is emitted.
- Second make pulse while busy=1 → ignored. Exactly one sequence is emitted, and busy falls once.
- resetN low in the middle of bit 5 → ps2_clk=1 and ps2_data=1 immediately, busy=0. A make after release restarts from the start bit cleanly.
- Loopback into the PS/2 receive path and a key decoder for code 9'h01C:
  - make → that decoder's keyIsPressed=1 and its toggle flips.
  - brakee → keyIsPressed=0.
